gpr_scoreboard: RTL and testbench
=================================

# gpr_scoreboard

Parametrised general-purpose register file for the ID stage with N read ports, EX/MEM/WB forwarding, and a second write port for long-latency results (divider, cache-miss loads). A per-register busy scoreboard tracks outstanding long-latency writes. It raises `stallreq` to the pipeline controller on RAW hazards against busy or non-forwardable producers, and on WAW hazards against busy registers.

## Interface
Parameters:
- `DW`, 32: data width.
- `NREG`, 32: number of registers; register 0 hardwired to zero.
- `AW`, 5: address width; `2**AW >= NREG`.
- `NRD`, 2: number of read ports.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ren`  in  NRD  per-port read enable (port i = bit i).
- `raddr`  in  NRD*AW  read addresses, port i at [i*AW +: AW].
- `rdata`  out  NRD*DW  read data, port i at [i*DW +: DW]; combinational.
- `id_wen`  in  1  instruction in ID writes a register (WAW check).
- `id_waddr`  in  AW  destination of instruction in ID.
- `ex_wen`, `ex_waddr` (AW), `ex_wdata` (DW), `ex_nofwd` (1)  in  EX-stage producer; `nofwd` means data not yet valid.
- `mem_wen`, `mem_waddr`, `mem_wdata`, `mem_nofwd`  in  MEM-stage producer, same widths.
- `we`, `waddr` (AW), `wdata` (DW)  in  WB write port.
- `lwb_we`, `lwb_waddr` (AW), `lwb_wdata` (DW)  in  long-latency completion write port; clears busy.
- `sb_set`  in  1  long-latency op issuing this cycle; marks `sb_addr` busy.
- `sb_addr`  in  AW  destination of issuing long op.
- `busy`  out  NREG  registered scoreboard vector; bit 0 always 0.
- `stallreq`  out  1  combinational stall request to ID.

## Operation
- Reset: all GPRs cleared to 0, `busy` cleared to 0. After reset, every `rdata` = 0 and `stallreq` = 0 given idle inputs.
- Writes: `we` writes `wdata` to `GPR[waddr]`; `lwb_we` writes `lwb_wdata` to `GPR[lwb_waddr]`. If both target the same address in the same cycle, `lwb` wins. Writes to address 0 are discarded.
- Read mux per port, first match wins:
  - `raddr == 0` → 0
  - EX hit (`ex_wen`, addr match) → `ex_wdata`
  - MEM hit → `mem_wdata`
  - `lwb` hit → `lwb_wdata`
  - WB hit → `wdata`
  - otherwise `GPR[raddr]`.
- Port i is valid when `ren[i] && raddr_i != 0`.
- Scoreboard: `busy[a]` is set next cycle when `sb_set && sb_addr == a`, and cleared next cycle when `lwb_we && lwb_waddr == a`. Simultaneous set and clear of the same register: set wins. `sb_addr == 0` is ignored. `sb_set` to an already-busy register does not occur, because the WAW stall prevents it.
- `stallreq` is the OR of:
  - For any valid port: EX hit with `ex_nofwd`.
  - For any valid port: MEM hit with `mem_nofwd`.
  - For any valid port: `busy[raddr]` and not a same-cycle `lwb` hit.
  - WAW: `id_wen && id_waddr != 0 && busy[id_waddr]` and not a same-cycle `lwb` clear of that register.
- An EX or MEM hit that is not stalled masks `busy` for that port; the younger producer is authoritative.

## Timing
- Read and forwarding latency: 0 cycles, combinational from address and bypass inputs.
- Write-to-array: visible via `GPR` the cycle after the write; same-cycle visibility is via the bypass.
- `busy` update: 1 cycle after `sb_set` / `lwb_we`. `stallreq` reflects the same-cycle `lwb` clear with no bubble.
- `rst` asserted mid-operation clears all state at the next edge. Pending long ops are dropped; the pipeline flushes them.

## Configuration
- `RF_WB_BYPASS_EN` defined: WB and `lwb` same-cycle forwarding as described.
- `RF_WB_BYPASS_EN` undefined:
  - WB and `lwb` terms are removed from the read mux.
  - A valid port hitting a same-cycle `we` or `lwb_we` address raises `stallreq` for that cycle instead.
  - The busy-clear masking via `lwb` is also removed; stall holds until `busy` drops. This adds one cycle of latency.

## Test plan
- Reset: preload r5 = 0x1234, pulse `rst` → next cycle `rdata` port0 on r5 = 0, `busy` = 0.
- Forward priority: EX r3 = 0xA, MEM r3 = 0xB, WB r3 = 0xC, all same cycle → port0 r3 reads 0xA, `stallreq` = 0. Drop EX → reads 0xB.
- Nofwd: EX writes r7 with `ex_nofwd` = 1, port1 reads r7 → `stallreq` = 1. Same with `ren[1]` = 0 → `stallreq` = 0.
- Scoreboard: `sb_set` r9 → `busy[9]` = 1 next cycle; read r9 → `stallreq` = 1. `lwb_we` r9 = 0x55 → same cycle `rdata` = 0x55, `stallreq` = 0; `busy[9]` = 0 next cycle.
- WAW and collisions: `busy[4]` = 1, `id_wen` r4 → `stallreq` = 1. Same-cycle `sb_set` r6 and `lwb_we` r6 → `busy[6]` = 1. `we` and `lwb_we` both r8 → r8 = `lwb_wdata`.
- Macro off: `we` r2 = 0x77 with port0 reading r2 → `stallreq` = 1; next cycle reads 0x77 with `stallreq` = 0.

Source files
------------

// File: rtl/gpr_scoreboard.sv
// ID-stage register file: N read ports, EX/MEM/WB forwarding, long-latency write port and busy scoreboard.
// Define RF_WB_BYPASS_EN to forward same-cycle WB/lwb writes; otherwise those collisions stall one cycle.
module gpr_scoreboard #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      ren,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*DW-1:0]   rdata,
    input  logic                id_wen,
    input  logic [AW-1:0]       id_waddr,
    input  logic                ex_wen,
    input  logic [AW-1:0]       ex_waddr,
    input  logic [DW-1:0]       ex_wdata,
    input  logic                ex_nofwd,
    input  logic                mem_wen,
    input  logic [AW-1:0]       mem_waddr,
    input  logic [DW-1:0]       mem_wdata,
    input  logic                mem_nofwd,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       wdata,
    input  logic                lwb_we,
    input  logic [AW-1:0]       lwb_waddr,
    input  logic [DW-1:0]       lwb_wdata,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic [NREG-1:0]     busy,
    output logic                stallreq
);

    logic [DW-1:0]     r_gpr [NREG];
    logic [NREG-1:0]   r_busy;
    logic [2**AW-1:0]  w_busy_ext;
    logic [NRD-1:0]    w_port_stall;
    logic              w_lwb_clr_id;
    logic              w_waw_stall;

    // NOTE: the array is reset explicitly because reads after reset must return zero,
    // not whatever the storage powered up with.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values;
            // the lwb write is placed last so it wins an address collision with WB.
            if (we && waddr != '0 && int'(waddr) < NREG) r_gpr[waddr] <= wdata;
            if (lwb_we && lwb_waddr != '0 && int'(lwb_waddr) < NREG) r_gpr[lwb_waddr] <= lwb_wdata;
        end
    end

    // Bit 0 is only ever reset, so it stays zero; set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int a = 1; a < NREG; a++) begin
                if (sb_set && int'(sb_addr) == a)          r_busy[a] <= 1'b1;
                else if (lwb_we && int'(lwb_waddr) == a)   r_busy[a] <= 1'b0;
            end
        end
    end

    // NOTE: default first so every path assigns the whole vector and no latch is inferred.
    always_comb begin
        w_busy_ext             = '0;
        w_busy_ext[NREG-1:0]   = r_busy;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0] w_ra;
        logic          w_valid;
        logic          w_ex_hit;
        logic          w_mem_hit;
        logic          w_wb_hit;
        logic          w_lwb_hit;
        logic          w_busy_hit;
        logic [DW-1:0] w_arr;

        assign w_ra       = raddr[p*AW +: AW];
        assign w_valid    = ren[p] && (w_ra != '0);
        assign w_ex_hit   = ex_wen  && (ex_waddr  == w_ra);
        assign w_mem_hit  = mem_wen && (mem_waddr == w_ra);
        assign w_wb_hit   = we      && (waddr     == w_ra);
        assign w_lwb_hit  = lwb_we  && (lwb_waddr == w_ra);
        assign w_busy_hit = w_busy_ext[w_ra];
        assign w_arr      = (int'(w_ra) < NREG) ? r_gpr[w_ra] : '0;

`ifdef RF_WB_BYPASS_EN
        assign rdata[p*DW +: DW] = (w_ra == '0) ? '0        :
                                   w_ex_hit     ? ex_wdata  :
                                   w_mem_hit    ? mem_wdata :
                                   w_lwb_hit    ? lwb_wdata :
                                   w_wb_hit     ? wdata     : w_arr;
        // A younger EX/MEM producer hides busy; a completing lwb releases it this cycle.
        assign w_port_stall[p] = w_valid && ((w_ex_hit && ex_nofwd) || (w_mem_hit && mem_nofwd) ||
                                 (!w_ex_hit && !w_mem_hit && w_busy_hit && !w_lwb_hit));
`else
        assign rdata[p*DW +: DW] = (w_ra == '0) ? '0        :
                                   w_ex_hit     ? ex_wdata  :
                                   w_mem_hit    ? mem_wdata : w_arr;
        // Without the WB bypass, a same-cycle array write is only readable next cycle.
        assign w_port_stall[p] = w_valid && ((w_ex_hit && ex_nofwd) || (w_mem_hit && mem_nofwd) ||
                                 w_wb_hit || w_lwb_hit ||
                                 (!w_ex_hit && !w_mem_hit && w_busy_hit));
`endif
    end

`ifdef RF_WB_BYPASS_EN
    assign w_lwb_clr_id = lwb_we && (lwb_waddr == id_waddr);
`else
    assign w_lwb_clr_id = 1'b0;
`endif

    assign w_waw_stall = id_wen && (id_waddr != '0) && w_busy_ext[id_waddr] && !w_lwb_clr_id;
    assign stallreq    = (|w_port_stall) || w_waw_stall;
    assign busy        = r_busy;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Self-checking bench for gpr_scoreboard: table-driven forwarding vectors plus scoreboard,
// collision and reset sequences; expectations follow RF_WB_BYPASS_EN when it is defined.
module tb_gpr_scoreboard;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD-1:0]    ren;
    logic [AW-1:0]     ra0, ra1;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [DW-1:0]     rd0, rd1;
    logic              id_wen;
    logic [AW-1:0]     id_waddr;
    logic              ex_wen, ex_nofwd, mem_wen, mem_nofwd, we, lwb_we, sb_set;
    logic [AW-1:0]     ex_waddr, mem_waddr, waddr, lwb_waddr, sb_addr;
    logic [DW-1:0]     ex_wdata, mem_wdata, wdata, lwb_wdata;
    logic [NREG-1:0]   busy;
    logic              stallreq;

    assign raddr = {ra1, ra0};
    assign rd0   = rdata[DW-1:0];
    assign rd1   = rdata[2*DW-1:DW];

    always #5 clk = ~clk;

    gpr_scoreboard #(.DW(DW), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata),
        .id_wen(id_wen), .id_waddr(id_waddr),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_nofwd(ex_nofwd),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_nofwd(mem_nofwd),
        .we(we), .waddr(waddr), .wdata(wdata),
        .lwb_we(lwb_we), .lwb_waddr(lwb_waddr), .lwb_wdata(lwb_wdata),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy), .stallreq(stallreq)
    );

    typedef struct {
        string       name;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        es;
    } exp_t;

    typedef struct {
        logic [1:0]  ren;
        logic [4:0]  ra0, ra1;
        logic        exw;  logic [4:0] exa;  logic [31:0] exd;  logic exn;
        logic        mw;   logic [4:0] ma;   logic [31:0] md;   logic mn;
        logic        idw;  logic [4:0] ida;
        logic [31:0] e0, e1;
        logic        es;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[11];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ren = '0; ra0 = '0; ra1 = '0; id_wen = 1'b0; id_waddr = '0;
        ex_wen = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_nofwd = 1'b0;
        mem_wen = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_nofwd = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        lwb_we = 1'b0; lwb_waddr = '0; lwb_wdata = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are already driven: queue the expectation, compare mid-cycle, move past next edge.
    task automatic cyc(input string name, input logic [31:0] e0, input logic [31:0] e1, input logic es);
        exp_t x;
        x.name = name; x.e0 = e0; x.e1 = e1; x.es = es;
        exp_q.push_back(x);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            x = exp_q.pop_front();
            check({x.name, "_rd0"},   {32'h0, rd0}, {32'h0, x.e0});
            check({x.name, "_rd1"},   {32'h0, rd1}, {32'h0, x.e1});
            check({x.name, "_stall"}, {63'h0, stallreq}, {63'h0, x.es});
        end
        tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0; waddr = '0; wdata = '0;
    endtask

    initial begin
        //            ren    ra0    ra1    exw   exa    exd        exn   mw    ma     md         mn    idw   ida    e0         e1         es
        vecs[0]  = '{2'b11, 5'd3,  5'd7,  1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'h33,    32'h77,    1'b0};
        vecs[1]  = '{2'b11, 5'd0,  5'd10, 1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'h0,     32'hAA,    1'b0};
        vecs[2]  = '{2'b11, 5'd3,  5'd7,  1'b1, 5'd3,  32'hA,     1'b0, 1'b1, 5'd3,  32'hB,     1'b0, 1'b0, 5'd0,  32'hA,     32'h77,    1'b0};
        vecs[3]  = '{2'b11, 5'd3,  5'd7,  1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 5'd3,  32'hB,     1'b0, 1'b0, 5'd0,  32'hB,     32'h77,    1'b0};
        vecs[4]  = '{2'b10, 5'd3,  5'd7,  1'b1, 5'd7,  32'hE,     1'b1, 1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'h33,    32'hE,     1'b1};
        vecs[5]  = '{2'b01, 5'd3,  5'd7,  1'b1, 5'd7,  32'hE,     1'b1, 1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'h33,    32'hE,     1'b0};
        vecs[6]  = '{2'b11, 5'd10, 5'd3,  1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 5'd10, 32'hF,     1'b1, 1'b0, 5'd0,  32'hF,     32'h33,    1'b1};
        vecs[7]  = '{2'b11, 5'd0,  5'd0,  1'b1, 5'd0,  32'h99,    1'b1, 1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'h0,     32'h0,     1'b0};
        vecs[8]  = '{2'b11, 5'd3,  5'd7,  1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 5'd4,  32'h33,    32'h77,    1'b0};
        vecs[9]  = '{2'b00, 5'd3,  5'd7,  1'b1, 5'd3,  32'hD,     1'b1, 1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 5'd0,  32'hD,     32'h77,    1'b0};
        vecs[10] = '{2'b11, 5'd3,  5'd7,  1'b1, 5'd3,  32'hC1,    1'b0, 1'b1, 5'd7,  32'hC2,    1'b0, 1'b0, 5'd0,  32'hC1,    32'hC2,    1'b0};

        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset_busy", {32'h0, busy}, 64'h0);
        ren = 2'b11; ra0 = 5'd5; ra1 = 5'd31;
        cyc("reset_rd", 32'h0, 32'h0, 1'b0);

        // Preload, set a pending long op, then reset mid-operation
        idle();
        wr(5'd5, 32'h1234);
        ren = 2'b01; ra0 = 5'd5;
        cyc("preload_r5", 32'h1234, 32'h0, 1'b0);
        sb_set = 1'b1; sb_addr = 5'd11;
        tick();
        sb_set = 1'b0; sb_addr = '0;
        check("busy_r11_set", {32'h0, busy}, 64'h1 << 11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("busy_after_rst", {32'h0, busy}, 64'h0);
        cyc("rst_r5", 32'h0, 32'h0, 1'b0);

        // Table of forwarding / nofwd vectors over a known array state
        idle();
        wr(5'd3, 32'h33);
        wr(5'd7, 32'h77);
        wr(5'd10, 32'hAA);
        for (int i = 0; i < 11; i++) begin
            ren = vecs[i].ren; ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
            ex_wen = vecs[i].exw; ex_waddr = vecs[i].exa; ex_wdata = vecs[i].exd; ex_nofwd = vecs[i].exn;
            mem_wen = vecs[i].mw; mem_waddr = vecs[i].ma; mem_wdata = vecs[i].md; mem_nofwd = vecs[i].mn;
            id_wen = vecs[i].idw; id_waddr = vecs[i].ida;
            cyc($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].es);
        end

        // Forward priority including WB; WB write lands in the array
        idle();
        ren = 2'b01; ra0 = 5'd3;
        ex_wen = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'hA;
        mem_wen = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hB;
        we = 1'b1; waddr = 5'd3; wdata = 32'hC;
        cyc("prio_ex", 32'hA, 32'h0, BYP ? 1'b0 : 1'b1);
        ex_wen = 1'b0; we = 1'b0;
        cyc("prio_mem", 32'hB, 32'h0, 1'b0);
        mem_wen = 1'b0;
        cyc("prio_arr", 32'hC, 32'h0, 1'b0);

        // Scoreboard set, stall, lwb completion
        idle();
        ren = 2'b01; ra0 = 5'd9;
        sb_set = 1'b1; sb_addr = 5'd9;
        cyc("sb_issue", 32'h0, 32'h0, 1'b0);
        sb_set = 1'b0; sb_addr = '0;
        check("busy_r9_set", {32'h0, busy}, 64'h1 << 9);
        cyc("sb_stall", 32'h0, 32'h0, 1'b1);
        lwb_we = 1'b1; lwb_waddr = 5'd9; lwb_wdata = 32'h55;
        cyc("sb_lwb", BYP ? 32'h55 : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1);
        lwb_we = 1'b0;
        check("busy_r9_clr", {32'h0, busy}, 64'h0);
        cyc("sb_after", 32'h55, 32'h0, 1'b0);

        // WAW against a busy register
        idle();
        sb_set = 1'b1; sb_addr = 5'd4;
        cyc("waw_issue", 32'h0, 32'h0, 1'b0);
        sb_set = 1'b0;
        check("busy_r4_set", {32'h0, busy}, 64'h1 << 4);
        id_wen = 1'b1; id_waddr = 5'd4;
        cyc("waw_stall", 32'h0, 32'h0, 1'b1);
        lwb_we = 1'b1; lwb_waddr = 5'd4; lwb_wdata = 32'h44;
        cyc("waw_lwb", 32'h0, 32'h0, BYP ? 1'b0 : 1'b1);
        lwb_we = 1'b0;
        check("busy_r4_clr", {32'h0, busy}, 64'h0);
        cyc("waw_free", 32'h0, 32'h0, 1'b0);

        // Same-cycle set and clear of r6: set wins
        idle();
        sb_set = 1'b1; sb_addr = 5'd6;
        lwb_we = 1'b1; lwb_waddr = 5'd6; lwb_wdata = 32'h66;
        cyc("setclr", 32'h0, 32'h0, 1'b0);
        idle();
        check("busy_r6_setwins", {32'h0, busy}, 64'h1 << 6);
        lwb_we = 1'b1; lwb_waddr = 5'd6; lwb_wdata = 32'h67;
        cyc("r6_clear", 32'h0, 32'h0, 1'b0);
        idle();
        check("busy_r6_clr", {32'h0, busy}, 64'h0);
        ren = 2'b01; ra0 = 5'd6;
        cyc("r6_read", 32'h67, 32'h0, 1'b0);

        // WB and lwb both write r8: lwb wins
        idle();
        we = 1'b1; waddr = 5'd8; wdata = 32'h1;
        lwb_we = 1'b1; lwb_waddr = 5'd8; lwb_wdata = 32'h88;
        cyc("dual_wr", 32'h0, 32'h0, 1'b0);
        idle();
        ren = 2'b01; ra0 = 5'd8;
        cyc("dual_rd", 32'h88, 32'h0, 1'b0);

        // sb_set to r0 is ignored
        idle();
        sb_set = 1'b1; sb_addr = 5'd0;
        cyc("sb_r0", 32'h0, 32'h0, 1'b0);
        sb_set = 1'b0;
        check("busy_r0", {32'h0, busy}, 64'h0);

        // Same-cycle WB / lwb hit on a read port, no scoreboard involvement
        idle();
        ren = 2'b01; ra0 = 5'd2;
        we = 1'b1; waddr = 5'd2; wdata = 32'h77;
        cyc("wb_same", BYP ? 32'h77 : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1);
        we = 1'b0;
        cyc("wb_next", 32'h77, 32'h0, 1'b0);
        idle();
        ren = 2'b10; ra1 = 5'd12;
        lwb_we = 1'b1; lwb_waddr = 5'd12; lwb_wdata = 32'h12;
        cyc("lwb_same", 32'h0, BYP ? 32'h12 : 32'h0, BYP ? 1'b0 : 1'b1);
        lwb_we = 1'b0;
        cyc("lwb_next", 32'h0, 32'h12, 1'b0);

        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
